matrix_disp_reader: RTL and testbench

MATRIX_DISP_READER -- requirements
Module: matrix_disp_reader

---
 rtl/matrix_disp_reader.sv | 214 +++++++++++++++++++++
 tb/tb_matrix_disp_reader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_disp_reader.sv
// matrix_disp_reader
//   Reads one stored matrix (up to 5x5, 8-bit elements) out of an external
//   storage with a fixed one-cycle read latency. Elements are delivered
//   row-major over a valid/ready stream, with end-of-row and end-of-matrix
//   markers.
//
// Ports
//   clk        in   system clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   start      in   one-cycle request to read out a matrix (ignored while busy)
//   matrix_id  in   [3:0] matrix to read, sampled with start
//   dim_m      in   [2:0] row count, sampled with start, legal 1..5
//   dim_n      in   [2:0] column count, sampled with start, legal 1..5
//   rd_en      out  read strobe to storage
//   rd_id      out  [3:0] matrix id presented with rd_en (0 otherwise)
//   rd_addr    out  [4:0] element index row*dim_n+col (0 when rd_en=0)
//   rd_data    in   [7:0] storage data, valid one cycle after rd_en
//   out_data   out  [7:0] element being delivered (0 when out_valid=0)
//   out_valid  out  out_data/out_eol/out_last valid
//   out_ready  in   downstream accepts when high together with out_valid
//   out_eol    out  element is the last of its row
//   out_last   out  element is the last of the matrix
//   busy       out  readout in progress
//   done       out  one-cycle pulse after the final element is accepted
//   error      out  one-cycle pulse after a start with illegal dimensions

module matrix_disp_reader (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] matrix_id,
  input  logic [2:0] dim_m,
  input  logic [2:0] dim_n,
  output logic       rd_en,
  output logic [3:0] rd_id,
  output logic [4:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_eol,
  output logic       out_last,
  output logic       busy,
  output logic       done,
  output logic       error
);

  // state  | meaning
  // -------+----------------------------------------------------------
  // IDLE   | waiting for start; illegal dims produce an error pulse
  // READ   | rd_en asserted for the current element address
  // WAIT   | storage data arrives; captured into the output register
  // SEND   | out_valid held until downstream accepts the element
  // DONE   | one-cycle done pulse, then back to IDLE

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t     state_q;

  // Latched request and element position
  logic [3:0] id_q;
  logic [2:0] m_q;
  logic [2:0] n_q;
  logic [2:0] row_q;
  logic [2:0] col_q;
  logic [4:0] addr_q;

  // Registered outputs
  logic       rd_en_q;
  logic [3:0] rd_id_q;
  logic [4:0] rd_addr_q;
  logic [7:0] out_data_q;
  logic       out_valid_q;
  logic       out_eol_q;
  logic       out_last_q;
  logic       busy_q;
  logic       done_q;
  logic       error_q;

  // Position bookkeeping
  logic       dims_ok;
  logic       col_end;
  logic       row_end;
  logic [2:0] row_d;
  logic [2:0] col_d;
  logic [4:0] addr_d;

  always_comb begin
    dims_ok = (dim_m != 3'd0) && (dim_m <= 3'd5) &&
              (dim_n != 3'd0) && (dim_n <= 3'd5);
    col_end = (col_q == (n_q - 3'd1));
    row_end = (row_q == (m_q - 3'd1));
    addr_d  = addr_q + 5'd1;
    row_d   = row_q;
    col_d   = col_q + 3'd1;
    if (col_end) begin
      col_d = 3'd0;
      row_d = row_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      id_q        <= '0;
      m_q         <= '0;
      n_q         <= '0;
      row_q       <= '0;
      col_q       <= '0;
      addr_q      <= '0;
      rd_en_q     <= 1'b0;
      rd_id_q     <= '0;
      rd_addr_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_eol_q   <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      // Strobe-type outputs default low; the read bus is zeroed whenever
      // rd_en is not asserted.
      rd_en_q   <= 1'b0;
      rd_id_q   <= '0;
      rd_addr_q <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (dims_ok) begin
              id_q      <= matrix_id;
              m_q       <= dim_m;
              n_q       <= dim_n;
              row_q     <= '0;
              col_q     <= '0;
              addr_q    <= '0;
              rd_en_q   <= 1'b1;
              rd_id_q   <= matrix_id;
              rd_addr_q <= '0;
              busy_q    <= 1'b1;
              state_q   <= S_READ;
            end else begin
              error_q   <= 1'b1;
            end
          end
        end

        S_READ: begin
          // The read strobe was issued on entry; storage answers next cycle.
          state_q <= S_WAIT;
        end

        S_WAIT: begin
          out_data_q  <= rd_data;
          out_eol_q   <= col_end;
          out_last_q  <= col_end && row_end;
          out_valid_q <= 1'b1;
          state_q     <= S_SEND;
        end

        S_SEND: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_eol_q   <= 1'b0;
            out_last_q  <= 1'b0;
            if (out_last_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              row_q     <= row_d;
              col_q     <= col_d;
              addr_q    <= addr_d;
              rd_en_q   <= 1'b1;
              rd_id_q   <= id_q;
              rd_addr_q <= addr_d;
              state_q   <= S_READ;
            end
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_id     = rd_id_q;
  assign rd_addr   = rd_addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_eol   = out_eol_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_matrix_disp_reader.sv
module tb_matrix_disp_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] matrix_id;
  logic [2:0] dim_m;
  logic [2:0] dim_n;
  logic       rd_en;
  logic [3:0] rd_id;
  logic [4:0] rd_addr;
  logic [7:0] rd_data = 8'hEE;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_eol;
  logic       out_last;
  logic       busy;
  logic       done;
  logic       error;

  int n_cmp = 0;
  int n_err = 0;

  logic [4:0] rq_addr[$];
  logic [3:0] rq_id[$];
  logic [9:0] xq[$];      // {last, eol, data} of each accepted element
  int         done_cnt = 0;
  int         err_cnt  = 0;

  matrix_disp_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .matrix_id (matrix_id),
    .dim_m     (dim_m),
    .dim_n     (dim_n),
    .rd_en     (rd_en),
    .rd_id     (rd_id),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_eol   (out_eol),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Storage: data = addr + 0x10, valid only in the cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) rd_data <= 8'h10 + {3'b000, rd_addr};
    else       rd_data <= 8'hEE;
  end

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: log reads, transfers, pulses; check idle-zero rules.
  always @(negedge clk) begin
    if (rd_en) begin
      rq_addr.push_back(rd_addr);
      rq_id.push_back(rd_id);
    end else begin
      chk_val("rd_bus_idle_zero", {rd_id, rd_addr}, 0);
    end
    if (out_valid) begin
      if (out_ready) xq.push_back({out_last, out_eol, out_data});
    end else begin
      chk_val("out_idle_zero", {out_eol, out_last, out_data}, 0);
    end
    if (done)  done_cnt++;
    if (error) err_cnt++;
  end

  task automatic clear_log();
    rq_addr.delete();
    rq_id.delete();
    xq.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  task automatic do_start(input logic [3:0] id, input logic [2:0] m, input logic [2:0] n);
    @(posedge clk); #1;
    start = 1'b1; matrix_id = id; dim_m = m; dim_n = n;
    @(posedge clk); #1;
    start = 1'b0; matrix_id = '0; dim_m = '0; dim_n = '0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk_val("done_within_budget", seen, 1);
  endtask

  task automatic check_seq(input int cnt, input int n, input logic [3:0] id);
    chk_val("seq_read_count", rq_addr.size(), cnt);
    chk_val("seq_xfer_count", xq.size(), cnt);
    for (int i = 0; i < cnt; i++) begin
      chk_val("seq_rd_addr", rq_addr[i], i);
      chk_val("seq_rd_id", rq_id[i], id);
      chk_val("seq_out_data", xq[i][7:0], 8'h10 + i);
      chk_val("seq_out_eol", xq[i][8], ((i % n) == n - 1) ? 1 : 0);
      chk_val("seq_out_last", xq[i][9], (i == cnt - 1) ? 1 : 0);
    end
  endtask

  logic [7:0] held;
  int         nrd;
  bit         seen_v;
  logic [2:0] bad_m[4] = '{3'd0, 3'd3, 3'd7, 3'd5};
  logic [2:0] bad_n[4] = '{3'd2, 3'd6, 3'd1, 3'd0};

  initial begin
    rst = 1'b1; start = 1'b0; matrix_id = '0; dim_m = '0; dim_n = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_val("reset_outputs", {rd_en, rd_id, rd_addr, out_data, out_valid,
                              out_eol, out_last, busy, done, error}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1x1 matrix, latency check
    clear_log();
    do_start(4'h7, 3'd1, 3'd1);
    @(negedge clk);
    chk_val("t1_rd_en", rd_en, 1);
    chk_val("t1_rd_addr", rd_addr, 0);
    chk_val("t1_rd_id", rd_id, 7);
    chk_val("t1_busy", busy, 1);
    @(negedge clk);
    chk_val("t2_rd_en", rd_en, 0);
    chk_val("t2_valid", out_valid, 0);
    @(negedge clk);
    chk_val("t3_valid", out_valid, 1);
    chk_val("t3_data_eol_last", {out_last, out_eol, out_data}, {2'b11, 8'h10});
    @(negedge clk);
    chk_val("t4_done", done, 1);
    chk_val("t4_busy", busy, 0);
    chk_val("t4_valid", out_valid, 0);
    @(negedge clk);
    chk_val("t5_done_cleared", done, 0);
    check_seq(1, 1, 4'h7);
    chk_val("t1x1_done_count", done_cnt, 1);

    // 2x3 matrix, id 3, always ready
    clear_log();
    do_start(4'h3, 3'd2, 3'd3);
    wait_done(60);
    repeat (4) @(negedge clk);
    check_seq(6, 3, 4'h3);
    chk_val("m2x3_done_count", done_cnt, 1);

    // Illegal dimensions
    clear_log();
    for (int t = 0; t < 4; t++) begin
      do_start(4'h1, bad_m[t], bad_n[t]);
      @(negedge clk);
      chk_val("bad_dims_error", error, 1);
      chk_val("bad_dims_busy", busy, 0);
      @(negedge clk);
      chk_val("bad_dims_error_pulse", error, 0);
      repeat (3) @(negedge clk);
    end
    chk_val("bad_dims_no_reads", rq_addr.size(), 0);
    chk_val("bad_dims_error_count", err_cnt, 4);

    // 2x2 with the first element stalled for 5 cycles
    clear_log();
    @(posedge clk); #1;
    out_ready = 1'b0;
    do_start(4'h2, 3'd2, 3'd2);
    seen_v = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) begin
        seen_v = 1'b1;
        break;
      end
    end
    chk_val("stall_valid_seen", seen_v, 1);
    held = out_data;
    chk_val("stall_first_data", held, 8'h10);
    nrd = rq_addr.size();
    repeat (5) begin
      @(negedge clk);
      chk_val("stall_data_stable", out_data, held);
      chk_val("stall_valid_held", out_valid, 1);
      chk_val("stall_no_extra_rd", rq_addr.size(), nrd);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done(60);
    repeat (4) @(negedge clk);
    check_seq(4, 2, 4'h2);
    chk_val("stall_done_count", done_cnt, 1);

    // Reset during SEND of element 2 of a 3x3 readout
    clear_log();
    do_start(4'h6, 3'd3, 3'd3);
    repeat (6) @(negedge clk);
    chk_val("rst_mid_valid", out_valid, 1);
    chk_val("rst_mid_data", out_data, 8'h11);
    rst = 1'b1;
    @(negedge clk);
    chk_val("rst_mid_outputs", {rd_en, rd_id, rd_addr, out_data, out_valid,
                                out_eol, out_last, busy, done, error}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk_val("rst_mid_no_done", done_cnt, 0);
    chk_val("rst_mid_reads", rq_addr.size(), 2);
    clear_log();
    do_start(4'h5, 3'd1, 3'd2);
    wait_done(40);
    repeat (3) @(negedge clk);
    check_seq(2, 2, 4'h5);
    chk_val("after_rst_done_count", done_cnt, 1);

    // start coincident with reset is ignored
    clear_log();
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; matrix_id = 4'h1; dim_m = 3'd1; dim_n = 3'd1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; matrix_id = '0; dim_m = '0; dim_n = '0;
    @(negedge clk);
    chk_val("rst_start_busy", busy, 0);
    repeat (4) @(negedge clk);
    chk_val("rst_start_no_reads", rq_addr.size(), 0);

    // Second start while busy is ignored
    clear_log();
    do_start(4'h2, 3'd2, 3'd2);
    do_start(4'h9, 3'd5, 3'd5);
    wait_done(60);
    repeat (10) @(negedge clk);
    check_seq(4, 2, 4'h2);
    chk_val("busy_start_done_count", done_cnt, 1);
    chk_val("busy_start_no_error", err_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
